// File: rtl/led_disp_pkg.sv
// Shared constants, state encoding and round-robin helper for the
// multiplexed 7-segment display arbiter.
package led_disp_pkg;

    localparam int NUM_CLIENTS = 4;
    localparam int NUM_DIGITS  = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] SEL_OFF   = 4'hF;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // Returns {found, index} of the first requester strictly after ptr in
    // cyclic order, with ptr itself considered last.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] cand;
        res = '0;
        for (int i = 1; i <= NUM_CLIENTS; i++) begin
            cand = ptr + 2'(i);
            if (!res[2] && req[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low gfedcba segment pattern (decimal point not included).
module hex_to_seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/led_display_arbiter.sv
// Round-robin sharing of the 4-digit multiplexed display between 4 clients,
// with grants held for a minimum number of scan frames.
module led_display_arbiter
    import led_disp_pkg::*;
#(
    parameter int DIV_BITS    = 16,
    parameter int HOLD_FRAMES = 8
) (
    input  logic                      CLKIN,
    input  logic                      RESET,
    input  logic [NUM_CLIENTS-1:0]    REQ,
    input  logic [16*NUM_CLIENTS-1:0] DATA,
    output logic [NUM_CLIENTS-1:0]    GNT,
    output logic [7:0]                SEG,
    output logic [3:0]                SEL,
    output logic                      FRAME
);

    localparam int              FC_W   = $clog2(HOLD_FRAMES + 1);
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(HOLD_FRAMES);

    state_t              state_q, state_d;
    logic [3:0]          gnt_q, gnt_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [DIV_BITS-1:0] presc_q, presc_d;
    logic [1:0]          idx_q, idx_d;
    logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d, fc_inc;
    logic [15:0]         shadow_q, shadow_d;
    logic [7:0]          seg_q, seg_d;
    logic [3:0]          sel_q, sel_d;
    logic [6:0]          digit_seg;
    logic [2:0]          pick;
    logic                tick, frame, take;

    assign tick  = &presc_q;
    assign frame = tick && (idx_q == 2'd3);

    assign GNT   = gnt_q;
    assign SEG   = seg_q;
    assign SEL   = sel_q;
    assign FRAME = frame;

    hex_to_seg u_hex (
        .nibble (shadow_q[{idx_q, 2'b00} +: 4]),
        .seg    (digit_seg)
    );

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= 2'd3;
            presc_q     <= '0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            shadow_q    <= '0;
            seg_q       <= SEG_BLANK;
            sel_q       <= SEL_OFF;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            shadow_q    <= shadow_d;
            seg_q       <= seg_d;
            sel_q       <= sel_d;
        end
    end

    // The holder is masked out, so in GRANT this is "next requester after holder".
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        presc_d     = presc_q + DIV_BITS'(1);
        idx_d       = tick ? idx_q + 2'd1 : idx_q;
        frame_cnt_d = frame_cnt_q;
        shadow_d    = shadow_q;
        take        = 1'b0;
        fc_inc      = (frame_cnt_q == FC_MAX) ? FC_MAX : frame_cnt_q + FC_W'(1);
        pick        = rr_pick(REQ & ~gnt_q, rr_ptr_q);

        case (state_q)
            IDLE: begin
                take = pick[2];
            end
            GRANT: begin
                if (frame) begin
                    frame_cnt_d = fc_inc;
                    shadow_d    = DATA[{rr_ptr_q, 4'b0000} +: 16];
                    if (!REQ[rr_ptr_q]) begin
                        if (pick[2]) begin
                            take = 1'b1;
                        end else begin
                            state_d = IDLE;
                            gnt_d   = '0;
                        end
                    end else if ((fc_inc == FC_MAX) && pick[2]) begin
                        take = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        // A new grant restarts the scan so the winner gets whole frames.
        if (take) begin
            state_d     = GRANT;
            gnt_d       = 4'b0001 << pick[1:0];
            rr_ptr_d    = pick[1:0];
            presc_d     = '0;
            idx_d       = '0;
            frame_cnt_d = '0;
            shadow_d    = DATA[{pick[1:0], 4'b0000} +: 16];
        end
    end

    always_comb begin
        seg_d = SEG_BLANK;
        sel_d = SEL_OFF;
        if (state_q == GRANT) begin
            sel_d = ~(4'b0001 << idx_q);
            seg_d = {1'b1, digit_seg};
        end
    end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Self-checking bench for led_display_arbiter with a fast prescaler
// (tick every 4 clocks) and a 2-frame hold.
module tb_led_display_arbiter;

    localparam logic [3:0]  M_ALL = 4'b1111;
    localparam logic [3:0]  M_GF  = 4'b1001;
    localparam logic [3:0]  M_G   = 4'b1000;
    localparam logic [63:0] D2    = 64'h0000_0000_0000_1234;
    localparam logic [63:0] D3    = 64'hFEDB_9ABC_5678_1234;
    localparam logic [63:0] D5    = 64'h0000_0000_0000_ABCD;

    typedef struct {
        string       name;
        int          adv;
        logic        rst;
        logic [3:0]  req;
        logic [63:0] data;
        logic [3:0]  mask;
        logic [3:0]  gnt;
        logic [7:0]  seg;
        logic [3:0]  sel;
        logic        frame;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] mask;
        logic [3:0] gnt;
        logic [7:0] seg;
        logic [3:0] sel;
        logic       frame;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] data;
    logic [3:0]  gnt;
    logic [7:0]  seg;
    logic [3:0]  sel;
    logic        frame;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    vec_t tbl[$];

    led_display_arbiter #(
        .DIV_BITS    (2),
        .HOLD_FRAMES (2)
    ) dut (
        .CLKIN (clock),
        .RESET (reset),
        .REQ   (req),
        .DATA  (data),
        .GNT   (gnt),
        .SEG   (seg),
        .SEL   (sel),
        .FRAME (frame)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(string n, int adv, logic rst, logic [3:0] rq, logic [63:0] d,
                                logic [3:0] m, logic [3:0] g, logic [7:0] s, logic [3:0] sl, logic f);
        vec_t v;
        v.name = n; v.adv = adv; v.rst = rst; v.req = rq; v.data = d;
        v.mask = m; v.gnt = g; v.seg = s; v.sel = sl; v.frame = f;
        return v;
    endfunction

    task automatic advance(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] rq, input logic [63:0] d, input int adv);
        reset = rst;
        req   = rq;
        data  = d;
        advance(adv);
    endtask

    task automatic pushExpect(input string n, input logic [3:0] m, input logic [3:0] g,
                              input logic [7:0] s, input logic [3:0] sl, input logic f);
        exp_t e;
        e.name = n; e.mask = m; e.gnt = g; e.seg = s; e.sel = sl; e.frame = f;
        sbq.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: queue empty, got 0 entries, required 1");
            return;
        end
        e = sbq.pop_front();
        if (e.mask[3]) begin
            checks++;
            if (gnt !== e.gnt) begin
                errors++;
                $display("[TB] FAIL %s gnt: got %h, required %h", e.name, gnt, e.gnt);
            end
        end
        if (e.mask[2]) begin
            checks++;
            if (seg !== e.seg) begin
                errors++;
                $display("[TB] FAIL %s seg: got %h, required %h", e.name, seg, e.seg);
            end
        end
        if (e.mask[1]) begin
            checks++;
            if (sel !== e.sel) begin
                errors++;
                $display("[TB] FAIL %s sel: got %h, required %h", e.name, sel, e.sel);
            end
        end
        if (e.mask[0]) begin
            checks++;
            if (frame !== e.frame) begin
                errors++;
                $display("[TB] FAIL %s frame: got %b, required %b", e.name, frame, e.frame);
            end
        end
    endtask

    task automatic expectNow(input string n, input logic [3:0] m, input logic [3:0] g,
                             input logic [7:0] s, input logic [3:0] sl, input logic f);
        pushExpect(n, m, g, s, sl, f);
        checkOutput();
    endtask

    task automatic runTable();
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].rst, tbl[i].req, tbl[i].data, tbl[i].adv);
            pushExpect(tbl[i].name, tbl[i].mask, tbl[i].gnt, tbl[i].seg, tbl[i].sel, tbl[i].frame);
            checkOutput();
        end
        tbl.delete();
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 4'h0, 64'h0, 2);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'hF;
        data  = D3;

        $display("[TB] reset held with all requests active");
        for (int i = 0; i < 5; i++) begin
            advance(1);
            expectNow("reset", M_ALL, 4'h0, 8'hFF, 4'hF, 1'b0);
        end

        $display("[TB] single client scan");
        tbl.push_back(mk("single_k1",  1,  1'b0, 4'b0001, D2, M_ALL, 4'b0001, 8'hFF, 4'hF, 1'b0));
        tbl.push_back(mk("single_k2",  1,  1'b0, 4'b0001, D2, M_ALL, 4'b0001, 8'h99, 4'hE, 1'b0));
        tbl.push_back(mk("single_k6",  4,  1'b0, 4'b0001, D2, M_ALL, 4'b0001, 8'hB0, 4'hD, 1'b0));
        tbl.push_back(mk("single_k10", 4,  1'b0, 4'b0001, D2, M_ALL, 4'b0001, 8'hA4, 4'hB, 1'b0));
        tbl.push_back(mk("single_k14", 4,  1'b0, 4'b0001, D2, M_ALL, 4'b0001, 8'hF9, 4'h7, 1'b0));
        tbl.push_back(mk("single_k16", 2,  1'b0, 4'b0001, D2, M_ALL, 4'b0001, 8'hF9, 4'h7, 1'b1));
        tbl.push_back(mk("single_k17", 1,  1'b0, 4'b0001, D2, M_ALL, 4'b0001, 8'hF9, 4'h7, 1'b0));
        tbl.push_back(mk("single_k18", 1,  1'b0, 4'b0001, D2, M_ALL, 4'b0001, 8'h99, 4'hE, 1'b0));
        tbl.push_back(mk("single_k32", 14, 1'b0, 4'b0001, D2, M_ALL, 4'b0001, 8'hF9, 4'h7, 1'b1));
        runTable();

        $display("[TB] rotation with all clients requesting");
        doReset();
        tbl.push_back(mk("rot_k1",   1,  1'b0, 4'hF, D3, M_GF,  4'b0001, 8'hFF, 4'hF, 1'b0));
        tbl.push_back(mk("rot_k32",  31, 1'b0, 4'hF, D3, M_GF,  4'b0001, 8'hFF, 4'hF, 1'b1));
        tbl.push_back(mk("rot_k33",  1,  1'b0, 4'hF, D3, M_GF,  4'b0010, 8'hFF, 4'hF, 1'b0));
        tbl.push_back(mk("rot_k34",  1,  1'b0, 4'hF, D3, M_ALL, 4'b0010, 8'h80, 4'hE, 1'b0));
        tbl.push_back(mk("rot_k64",  30, 1'b0, 4'hF, D3, M_GF,  4'b0010, 8'hFF, 4'hF, 1'b1));
        tbl.push_back(mk("rot_k65",  1,  1'b0, 4'hF, D3, M_G,   4'b0100, 8'hFF, 4'hF, 1'b0));
        tbl.push_back(mk("rot_k66",  1,  1'b0, 4'hF, D3, M_ALL, 4'b0100, 8'hC6, 4'hE, 1'b0));
        tbl.push_back(mk("rot_k97",  31, 1'b0, 4'hF, D3, M_G,   4'b1000, 8'hFF, 4'hF, 1'b0));
        tbl.push_back(mk("rot_k98",  1,  1'b0, 4'hF, D3, M_ALL, 4'b1000, 8'h83, 4'hE, 1'b0));
        tbl.push_back(mk("rot_k129", 31, 1'b0, 4'hF, D3, M_G,   4'b0001, 8'hFF, 4'hF, 1'b0));
        tbl.push_back(mk("rot_k130", 1,  1'b0, 4'hF, D3, M_ALL, 4'b0001, 8'h99, 4'hE, 1'b0));
        runTable();

        $display("[TB] holder releases mid-frame");
        doReset();
        applyStimulus(1'b0, 4'b0100, D3, 1);
        expectNow("rel_grant", M_ALL, 4'b0100, 8'hFF, 4'hF, 1'b0);
        applyStimulus(1'b0, 4'b0100, D3, 4);
        expectNow("rel_k5", M_ALL, 4'b0100, 8'hC6, 4'hE, 1'b0);
        applyStimulus(1'b0, 4'b0000, D3, 1);
        expectNow("rel_k6", M_ALL, 4'b0100, 8'h83, 4'hD, 1'b0);
        advance(4);
        expectNow("rel_k10", M_ALL, 4'b0100, 8'h88, 4'hB, 1'b0);
        advance(4);
        expectNow("rel_k14", M_ALL, 4'b0100, 8'h90, 4'h7, 1'b0);
        advance(2);
        expectNow("rel_frame", M_ALL, 4'b0100, 8'h90, 4'h7, 1'b1);
        advance(1);
        expectNow("rel_gnt_off", M_ALL, 4'b0000, 8'h90, 4'h7, 1'b0);
        advance(1);
        expectNow("rel_blank", M_ALL, 4'b0000, 8'hFF, 4'hF, 1'b0);

        $display("[TB] data change mid-frame");
        doReset();
        applyStimulus(1'b0, 4'b0001, D2, 1);
        expectNow("tear_grant", M_G, 4'b0001, 8'hFF, 4'hF, 1'b0);
        applyStimulus(1'b0, 4'b0001, D2, 8);
        applyStimulus(1'b0, 4'b0001, D5, 1);
        expectNow("tear_d2", M_ALL, 4'b0001, 8'hA4, 4'hB, 1'b0);
        advance(4);
        expectNow("tear_d3", M_ALL, 4'b0001, 8'hF9, 4'h7, 1'b0);
        advance(4);
        expectNow("tear_new_d0", M_ALL, 4'b0001, 8'hA1, 4'hE, 1'b0);
        advance(4);
        expectNow("tear_new_d1", M_ALL, 4'b0001, 8'hC6, 4'hD, 1'b0);
        advance(4);
        expectNow("tear_new_d2", M_ALL, 4'b0001, 8'h83, 4'hB, 1'b0);
        advance(4);
        expectNow("tear_new_d3", M_ALL, 4'b0001, 8'h88, 4'h7, 1'b0);

        $display("[TB] reset during grant");
        doReset();
        applyStimulus(1'b0, 4'b0001, D2, 9);
        expectNow("mid_pre", M_ALL, 4'b0001, 8'hB0, 4'hD, 1'b0);
        applyStimulus(1'b1, 4'b0110, D3, 1);
        expectNow("mid_reset", M_ALL, 4'b0000, 8'hFF, 4'hF, 1'b0);
        applyStimulus(1'b0, 4'b0110, D3, 1);
        expectNow("mid_regrant", M_ALL, 4'b0010, 8'hFF, 4'hF, 1'b0);
        advance(1);
        expectNow("mid_scan", M_ALL, 4'b0010, 8'h80, 4'hE, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
